uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 110 +++++++++++
 tb/tb_uart_tx_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - two-requester round-robin UART 8N1 transmitter
module uart_tx_sched #(
    parameter int CLK_DIV = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       txd,
    output logic       busy,
    output logic       grant_id
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] LP_LAST = 16'(CLK_DIV - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_last_grant;
    logic        r_grant_id;
    logic        r_ack0;
    logic        r_ack1;
    logic        r_txd;
    logic        r_busy;

    logic        w_tick;
    logic        w_any_req;
    logic        w_grant;

    assign w_tick    = (r_cnt == LP_LAST);
    assign w_any_req = req0 | req1;
    // On a tie the requester that did not own the previous frame wins.
    assign w_grant   = (req0 & req1) ? ~r_last_grant : req1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= 16'd0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'd0;
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_txd        <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_cnt  <= (r_state == IDLE || w_tick) ? 16'd0 : r_cnt + 16'd1;
            case (r_state)
                IDLE: begin
                    r_txd  <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_any_req) begin
                        r_state      <= START;
                        r_txd        <= 1'b0;
                        r_busy       <= 1'b1;
                        r_shift      <= w_grant ? data1 : data0;
                        r_ack0       <= ~w_grant;
                        r_ack1       <= w_grant;
                        r_grant_id   <= w_grant;
                        r_last_grant <= w_grant;
                        r_bit_idx    <= 3'd0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state   <= DATA;
                        r_txd     <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= 3'd0;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_txd     <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_txd   <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign txd      = r_txd;
    assign busy     = r_busy;
    assign grant_id = r_grant_id;
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched at CLK_DIV 104 and 2
module tb_uart_tx_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic       a_req0 = 0, a_req1 = 0, b_req0 = 0, b_req1 = 0;
    logic [7:0] a_data0 = 0, a_data1 = 0, b_data0 = 0, b_data1 = 0;
    logic       a_ack0, a_ack1, a_txd, a_busy, a_gid;
    logic       b_ack0, b_ack1, b_txd, b_busy, b_gid;

    typedef struct {logic gid; logic [7:0] data;} exp_t;
    exp_t exp_q[$];

    uart_tx_sched #(.CLK_DIV(104)) dut_a (
        .clk(clk), .rst(rst), .req0(a_req0), .data0(a_data0), .ack0(a_ack0),
        .req1(a_req1), .data1(a_data1), .ack1(a_ack1), .txd(a_txd), .busy(a_busy),
        .grant_id(a_gid));

    uart_tx_sched #(.CLK_DIV(2)) dut_b (
        .clk(clk), .rst(rst), .req0(b_req0), .data0(b_data0), .ack0(b_ack0),
        .req1(b_req1), .data1(b_data1), .ack1(b_ack1), .txd(b_txd), .busy(b_busy),
        .grant_id(b_gid));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic g_ack0(bit s); return s ? b_ack0 : a_ack0; endfunction
    function automatic logic g_ack1(bit s); return s ? b_ack1 : a_ack1; endfunction
    function automatic logic g_txd(bit s);  return s ? b_txd  : a_txd;  endfunction
    function automatic logic g_busy(bit s); return s ? b_busy : a_busy; endfunction
    function automatic logic g_gid(bit s);  return s ? b_gid  : a_gid;  endfunction

    task automatic push(input logic gid, input logic [7:0] data);
        exp_t e;
        e.gid = gid; e.data = data;
        exp_q.push_back(e);
    endtask

    // Waits for an ack on the selected DUT, then checks the whole frame against the queue head.
    task automatic check_frame(input bit sel, input bit drop, output int t_ack);
        int d, n;
        exp_t e;
        logic [9:0] got, want;
        bit steady, busy_ok, extra_ack;
        logic ch;
        d = sel ? 2 : 104;
        n = 0;
        while (!(g_ack0(sel) || g_ack1(sel)) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        t_ack = cyc;
        n_cmp++;
        if (!(g_ack0(sel) || g_ack1(sel))) begin
            $display("FAIL ack_timeout: got no ack after %0d cycles, required an ack", n);
            n_bad++;
            return;
        end
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_frame: got ack with empty scoreboard, required none");
            return;
        end
        e = exp_q.pop_front();
        ch = g_ack1(sel);
        n_cmp++;
        if ((g_ack0(sel) && g_ack1(sel)) || ch !== e.gid) begin
            $display("FAIL ack_channel: got ack0=%b ack1=%b, required ack%0d only",
                     g_ack0(sel), g_ack1(sel), e.gid);
            n_bad++;
        end
        n_cmp++;
        if (g_gid(sel) !== e.gid) begin
            $display("FAIL grant_id: got %b required %b", g_gid(sel), e.gid);
            n_bad++;
        end
        if (drop) begin
            if (sel) begin if (ch) b_req1 = 0; else b_req0 = 0; end
            else     begin if (ch) a_req1 = 0; else a_req0 = 0; end
        end
        got = '0; steady = 1; busy_ok = 1; extra_ack = 0;
        for (int k = 0; k < 10 * d; k++) begin
            if (k % d == 0) got[k / d] = g_txd(sel);
            else if (g_txd(sel) !== got[k / d]) steady = 0;
            if (g_busy(sel) !== 1'b1) busy_ok = 0;
            if (k > 0 && (g_ack0(sel) || g_ack1(sel))) extra_ack = 1;
            @(negedge clk);
        end
        want = {1'b1, e.data, 1'b0};
        n_cmp++;
        if (got !== want) begin
            $display("FAIL frame_bits: got %b required %b", got, want);
            n_bad++;
        end
        n_cmp++;
        if (!steady || !busy_ok) begin
            $display("FAIL bit_timing: got steady=%b busy=%b required 1 1", steady, busy_ok);
            n_bad++;
        end
        n_cmp++;
        if (extra_ack) begin
            $display("FAIL ack_in_frame: got extra ack during frame, required none");
            n_bad++;
        end
        n_cmp++;
        if (g_busy(sel) !== 1'b0 || g_txd(sel) !== 1'b1) begin
            $display("FAIL idle_after: got busy=%b txd=%b required 0 1", g_busy(sel), g_txd(sel));
            n_bad++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({a_txd, a_busy, a_ack0, a_ack1, a_gid} !== 5'b10000) begin
            $display("FAIL reset_a: got %b required 10000", {a_txd, a_busy, a_ack0, a_ack1, a_gid});
            n_bad++;
        end
        n_cmp++;
        if ({b_txd, b_busy, b_ack0, b_ack1, b_gid} !== 5'b10000) begin
            $display("FAIL reset_b: got %b required 10000", {b_txd, b_busy, b_ack0, b_ack1, b_gid});
            n_bad++;
        end
    endtask

    task automatic test_single();
        int t;
        a_data0 = 8'h55; a_req0 = 1; push(0, 8'h55);
        check_frame(0, 1, t);
    endtask

    task automatic test_tie();
        int t1, t2;
        do_reset();
        a_data0 = 8'hA3; a_data1 = 8'h3C; a_req0 = 1; a_req1 = 1;
        push(0, 8'hA3); push(1, 8'h3C);
        check_frame(0, 1, t1);
        check_frame(0, 1, t2);
        n_cmp++;
        if (t2 - t1 !== 1041) begin
            $display("FAIL tie_spacing: got %0d required 1041", t2 - t1);
            n_bad++;
        end
    endtask

    task automatic test_back_to_back();
        int t[4];
        a_data0 = 8'h11; a_data1 = 8'h22; a_req0 = 1; a_req1 = 1;
        push(0, 8'h11); push(1, 8'h22); push(0, 8'h5A); push(1, 8'h22);
        check_frame(0, 0, t[0]);
        a_data0 = 8'h5A;
        check_frame(0, 0, t[1]);
        check_frame(0, 1, t[2]);
        check_frame(0, 1, t[3]);
        for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (t[i] - t[i-1] !== 1041) begin
                $display("FAIL b2b_spacing%0d: got %0d required 1041", i, t[i] - t[i-1]);
                n_bad++;
            end
        end
    endtask

    task automatic test_div2();
        int t1, t2;
        b_data1 = 8'hFF; b_req1 = 1; push(1, 8'hFF);
        check_frame(1, 1, t1);
        b_data1 = 8'h00; b_req1 = 1; push(1, 8'h00);
        check_frame(1, 1, t2);
        n_cmp++;
        if (t2 - t1 !== 21) begin
            $display("FAIL div2_spacing: got %0d required 21", t2 - t1);
            n_bad++;
        end
    endtask

    task automatic test_late_req();
        int t1, t2;
        a_data0 = 8'hC5; a_req0 = 1;
        push(0, 8'hC5); push(1, 8'h96);
        fork
            check_frame(0, 1, t1);
            begin
                repeat (300) @(negedge clk);
                a_data1 = 8'h96; a_req1 = 1;
            end
        join
        check_frame(0, 1, t2);
        n_cmp++;
        if (t2 - t1 !== 1041) begin
            $display("FAIL late_req_spacing: got %0d required 1041", t2 - t1);
            n_bad++;
        end
    endtask

    task automatic test_abort();
        int n, t;
        bit seen;
        a_data0 = 8'hF0; a_req0 = 1;
        n = 0;
        while (!a_ack0 && n < 50) begin @(negedge clk); n++; end
        a_req0 = 0;
        n_cmp++;
        if (!a_ack0) begin
            $display("FAIL abort_ack: got no ack0 required ack0");
            n_bad++;
        end
        repeat (4 * 104 + 50) @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        n_cmp++;
        if ({a_txd, a_busy, a_ack0, a_ack1} !== 4'b1000) begin
            $display("FAIL abort_state: got %b required 1000", {a_txd, a_busy, a_ack0, a_ack1});
            n_bad++;
        end
        seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (a_ack0 || a_ack1 || a_busy || !a_txd) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            $display("FAIL abort_quiet: got activity after abort required none");
            n_bad++;
        end
        a_data0 = 8'h0F; a_req0 = 1; push(0, 8'h0F);
        check_frame(0, 1, t);
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_div2();
        test_late_req();
        test_abort();
        n_cmp++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_left: got %0d pending required 0", exp_q.size());
            n_bad++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
